// File: rtl/udp_rx.sv
// udp_rx: GMII receive parser that checks the preamble and the MAC/IPv4/UDP headers, then packs the UDP payload into 32-bit RAM words.
// Latency: a RAM write is registered one edge after the byte that completes the word. No backpressure: the GMII stream cannot be stalled.
module udp_rx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] BOARD_IP   = 32'hC0A8_0002,
  parameter logic [15:0] BOARD_PORT = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        reset,
  input  logic        e_rxdv,
  input  logic [7:0]  e_rxd,
  output logic        ram_wr_en,
  output logic [12:0] ram_wr_addr,
  output logic [31:0] ram_wr_data,
  output logic [3:0]  rx_state,
  output logic [13:0] rx_data_length,
  output logic        rx_done,
  output logic        rx_err
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PREAMBLE = 4'd1,
    MAC_HDR  = 4'd2,
    IP_HDR   = 4'd3,
    UDP_HDR  = 4'd4,
    DATA     = 4'd5,
    DONE     = 4'd6,
    DROP     = 4'd7
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [39:0] sh_q, sh_d;
  logic        bad_q, bad_d;
  logic [13:0] plen_q, plen_d;
  logic        first_q, first_d;
  logic        wr_en_q, wr_en_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [13:0] len_q, len_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Byte history with the current byte appended: multi-byte fields compare on their last byte.
  logic [47:0] sh_nxt;
  logic [15:0] udp_len;
  logic [15:0] pay16;
  logic        last_byte;

  assign sh_nxt    = {sh_q, e_rxd};
  assign udp_len   = sh_nxt[15:0];
  assign pay16     = udp_len - 16'd8;
  assign last_byte = (cnt_q == plen_q - 14'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    bad_d     = bad_q;
    plen_d    = plen_q;
    first_d   = first_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d     = len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (e_rxdv && e_rxd == 8'h55) begin
          state_d = PREAMBLE;
          cnt_d   = 14'd1;
        end
      end

      PREAMBLE: begin
        if (!e_rxdv) begin
          state_d = DROP;
          err_d   = 1'b1;
        end else if (cnt_q < 14'd7) begin
          if (e_rxd == 8'h55) begin
            cnt_d = cnt_q + 14'd1;
          end else begin
            state_d = DROP;
            err_d   = 1'b1;
          end
        end else if (e_rxd == 8'hD5) begin
          state_d = MAC_HDR;
          cnt_d   = 14'd0;
          bad_d   = 1'b0;
        end else begin
          state_d = DROP;
          err_d   = 1'b1;
        end
      end

      MAC_HDR: begin
        if (!e_rxdv) begin
          state_d = DROP;
        end else begin
          sh_d  = sh_nxt[39:0];
          cnt_d = cnt_q + 14'd1;
          if (cnt_q == 14'd5 && sh_nxt != BOARD_MAC && sh_nxt != 48'hFFFF_FFFF_FFFF) begin
            bad_d = 1'b1;
          end
          if (cnt_q == 14'd13) begin
            cnt_d = 14'd0;
            bad_d = 1'b0;
            state_d = (bad_q || sh_nxt[15:0] != 16'h0800) ? DROP : IP_HDR;
          end
        end
      end

      IP_HDR: begin
        if (!e_rxdv) begin
          state_d = DROP;
        end else begin
          sh_d  = sh_nxt[39:0];
          cnt_d = cnt_q + 14'd1;
          if ((cnt_q == 14'd0 && e_rxd != 8'h45) || (cnt_q == 14'd9 && e_rxd != 8'h11)) begin
            bad_d = 1'b1;
          end
          if (cnt_q == 14'd19) begin
            cnt_d = 14'd0;
            bad_d = 1'b0;
            state_d = (bad_q || sh_nxt[31:0] != BOARD_IP) ? DROP : UDP_HDR;
          end
        end
      end

      UDP_HDR: begin
        if (!e_rxdv) begin
          state_d = DROP;
        end else begin
          sh_d  = sh_nxt[39:0];
          cnt_d = cnt_q + 14'd1;
          if (cnt_q == 14'd3 && sh_nxt[15:0] != BOARD_PORT) begin
            state_d = DROP;
          end
          if (cnt_q == 14'd5) begin
            if (udp_len < 16'd8 || pay16 > 16'd1472) begin
              state_d = DROP;
              err_d   = 1'b1;
            end else begin
              plen_d = pay16[13:0];
            end
          end
          if (cnt_q == 14'd7) begin
            cnt_d   = 14'd0;
            first_d = 1'b1;
            state_d = (plen_q == 14'd0) ? DONE : DATA;
          end
        end
      end

      DATA: begin
        if (!e_rxdv) begin
          state_d = DROP;
          err_d   = 1'b1;
        end else begin
          sh_d  = sh_nxt[39:0];
          cnt_d = cnt_q + 14'd1;
          if (cnt_q[1:0] == 2'b11 || last_byte) begin
            wr_en_d   = 1'b1;
            // Left-justify a partial final word so its unused low bytes read as zero.
            wr_data_d = sh_nxt[31:0] << {~cnt_q[1:0], 3'b000};
            wr_addr_d = first_q ? 13'd0 : wr_addr_q + 13'd1;
            first_d   = 1'b0;
          end
          if (last_byte) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        len_d   = plen_q;
        done_d  = 1'b1;
        state_d = DROP;
      end

      DROP: begin
        if (!e_rxdv) begin
          state_d = IDLE;
        end
      end

      default: state_d = DROP;
    endcase
  end

  always_ff @(posedge e_rxc or posedge reset) begin
    if (reset) begin
      state_q   <= DROP;
      cnt_q     <= 14'd0;
      sh_q      <= 40'd0;
      bad_q     <= 1'b0;
      plen_q    <= 14'd0;
      first_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 13'd0;
      wr_data_q <= 32'd0;
      len_q     <= 14'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bad_q     <= bad_d;
      plen_q    <= plen_d;
      first_q   <= first_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign rx_state       = state_q;
  assign rx_data_length = len_q;
  assign rx_done        = done_q;
  assign rx_err         = err_q;

endmodule
